instr_fetch_ctrl: RTL



---
 rtl/instr_fetch_ctrl_pkg.sv | 25 ++
 rtl/instr_fetch_ctrl_queue.sv | 66 ++++++
 rtl/instr_fetch_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the SOIN-RV instruction fetch path.
// The reset PC and memory size defaults are shared with the instruction memory model.
package instr_fetch_ctrl_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam int              MEM_BYTES_DEFAULT = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  // The last byte of the word must lie inside memory; computed one bit wider so
  // a pc near 2^32 cannot wrap back into the legal range.
  function automatic logic pc_legal(input logic [XLEN-1:0] pc, input int mem_bytes);
    logic [XLEN:0] last_byte;
    last_byte = {1'b0, pc} + (XLEN+1)'(INSTR_BYTES - 1);
    return last_byte < (XLEN+1)'(mem_bytes);
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs.
// The head reads as zero while the queue is empty. A flush overrides push and pop.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] entry_reg [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_eff;
  logic             pop_eff;

  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign head     = empty ? '0 : entry_reg[rd_ptr_reg];
  assign pop_eff  = pop & ~empty & ~flush;
  assign push_eff = push & ~flush & (~full | pop_eff);

  // Data storage needs no reset: the head is masked by empty.
  always_ff @(posedge clk) begin
    if (push_eff) begin
      entry_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_eff) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push_eff && !pop_eff) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop_eff && !push_eff) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller: owns the pc, drives the instruction memory address, fills
// the fetch queue, handles redirects and records the first faulting pc.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int          QDEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fetch_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         fault_reg, fault_next;
  logic [31:0]  fault_pc_reg, fault_pc_next;

  logic                      push;
  logic                      pop;
  logic                      flush;
  logic                      q_full;
  logic                      q_empty;
  logic [$clog2(QDEPTH):0]   q_count;
  logic [63:0]               q_head;
  logic                      can_push;

  assign imem_addr = pc_reg;
  assign out_valid = (q_count != '0);
  assign out_pc    = q_head[63:32];
  assign out_instr = q_head[31:0];
  assign fault     = fault_reg;
  assign fault_pc  = fault_pc_reg;
  assign pop       = ~q_empty & out_ready;
  assign can_push  = ~q_full | pop;

  fetch_queue #(
    .WIDTH (64),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({pc_reg, imem_rdata}),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count),
    .head  (q_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      fault_reg    <= 1'b0;
      fault_pc_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      fault_reg    <= fault_next;
      fault_pc_reg <= fault_pc_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    fault_next    = fault_reg;
    fault_pc_next = fault_pc_reg;
    push          = 1'b0;
    flush         = 1'b0;
    // A redirect wins over every other action, including a concurrent pop.
    if (redirect_valid) begin
      flush      = 1'b1;
      pc_next    = redirect_pc;
      fault_next = 1'b0;
      state_next = FETCH;
    end else begin
      case (state_reg)
        IDLE:  state_next = FETCH;
        FETCH: begin
          if (fetch_en) begin
            if (!pc_legal(pc_reg, MEM_BYTES) || (pc_reg[1:0] != 2'b00)) begin
              fault_next    = 1'b1;
              fault_pc_next = pc_reg;
              state_next    = FAULT;
            end else if (can_push) begin
              push    = 1'b1;
              pc_next = pc_reg + 32'(INSTR_BYTES);
            end
          end
        end
        FAULT:   state_next = FAULT;
        default: state_next = IDLE;
      endcase
    end
  end

endmodule
